// File: rtl/de_arbiter.sv
// de_arbiter: round-robin arbiter sharing one drawing-engine write port among N_REQ requesters.
module de_arbiter #(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      de_req,
  output logic [ADDR_W-1:0]         de_addr,
  output logic [DATA_W-1:0]         de_data,
  input  logic                      de_ack
);
  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST);
  typedef enum logic {IDLE, OWN} state_t;
  state_t              r_state;
  logic [OW-1:0]       r_owner, r_last, w_next, w_off;
  logic [CW-1:0]       r_cnt;
  logic [2*N_REQ-1:0]  w_dbl;
  logic [N_REQ-1:0]    w_rot, w_onehot;
  logic                w_own, w_accept, w_others;
  // Rotate requests so bit 0 is the requester just after the last owner.
  assign w_dbl = {req, req};
  assign w_rot = N_REQ'(w_dbl >> (r_last + 1'b1));
  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (w_rot[k]) w_off = OW'(k);
    w_next = OW'((int'(r_last) + int'(w_off) + 1) % N_REQ);
  end
  assign w_own    = r_state == OWN;
  assign w_onehot = N_REQ'(1) << r_owner;
  assign w_others = |(req & ~w_onehot);
  assign de_req   = w_own & req[r_owner];
  assign w_accept = de_req & de_ack;
  assign ack      = w_accept ? w_onehot : '0;
  assign grant    = w_own ? w_onehot : '0;
  assign busy     = w_own;
  assign de_addr  = w_own ? addr[r_owner*ADDR_W +: ADDR_W] : '0;
  assign de_data  = w_own ? data[r_owner*DATA_W +: DATA_W] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= OW'(N_REQ - 1);
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (|req) begin
        r_state <= OWN;
        r_owner <= w_next;
        r_last  <= w_next;
        r_cnt   <= '0;
      end
    end else begin
      if (w_accept) r_cnt <= r_cnt + 1'b1;
      if (!req[r_owner] || (w_accept && &r_cnt && w_others)) r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_de_arbiter.sv
// tb_de_arbiter: scoreboard bench for de_arbiter with per-requester expected-beat queues.
module tb_de_arbiter;
  localparam int N = 2, AW = 18, DW = 16, MB = 16;
  logic clk = 0, rst = 1, de_ack = 0;
  logic [N-1:0] req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0] ack, grant, ack_s;
  logic busy, de_req;
  logic [AW-1:0] de_addr;
  logic [DW-1:0] de_data;
  int checks = 0, errors = 0;
  int rem [N];
  logic [AW-1:0] cur [N];
  logic [AW+DW-1:0] q0 [$], q1 [$];

  de_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .data(data), .ack(ack), .grant(grant),
    .busy(busy), .de_req(de_req), .de_addr(de_addr), .de_data(de_data), .de_ack(de_ack));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hC3A5;
  endfunction

  task automatic present(input int i);
    addr[i*AW +: AW] = cur[i];
    data[i*DW +: DW] = dat(cur[i]);
    req[i] = rem[i] > 0;
  endtask

  task automatic load(input int i, input int n, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    rem[i] = n;
    cur[i] = base;
    for (int k = 0; k < n; k++) begin
      a = base + AW'(k);
      if (i == 0) q0.push_back({a, dat(a)});
      else q1.push_back({a, dat(a)});
    end
    present(i);
  endtask

  task automatic step();
    logic [AW+DW-1:0] e;
    logic got;
    #1;
    ack_s = ack;
    if (ack_s != 0) begin
      checks++;
      got = 1;
      if (ack_s == 2'b01 && q0.size() != 0) e = q0.pop_front();
      else if (ack_s == 2'b10 && q1.size() != 0) e = q1.pop_front();
      else got = 0;
      if (!got) begin
        errors++;
        $display("FAIL sb_unexpected ack=%b q0=%0d q1=%0d", ack_s, q0.size(), q1.size());
      end else if ({de_addr, de_data} !== e) begin
        errors++;
        $display("FAIL sb_beat got=%h exp=%h", {de_addr, de_data}, e);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (ack_s[i]) begin
        rem[i]--;
        cur[i]++;
        present(i);
      end
  endtask

  task automatic drain();
    int n = 0;
    while ((rem[0] > 0 || rem[1] > 0 || q0.size() != 0 || q1.size() != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200 || q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain cycles=%0d q0=%0d q1=%0d exp_empty", n, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    de_ack = 1;
    load(0, 20, 18'h01000);
    load(1, 20, 18'h02000);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({grant, busy, de_req, ack, de_addr, de_data} !== '0) begin
        errors++;
        $display("FAIL reset grant=%b busy=%b de_req=%b ack=%b addr=%h exp_all_zero", grant, busy, de_req, ack, de_addr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp;
    rst = 0;
    step();
    for (int c = 0; c < 35; c++) begin
      exp = c < 16 ? 2'b01 : c == 16 ? 2'b00 : c < 33 ? 2'b10 : c == 33 ? 2'b00 : 2'b01;
      #1;
      checks++;
      if (grant !== exp || ack !== exp) begin
        errors++;
        $display("FAIL contention c=%0d grant=%b ack=%b exp=%b", c, grant, ack, exp);
      end
      step();
    end
    drain();
  endtask

  task automatic test_single();
    de_ack = 1;
    load(0, 3, 18'h00100);
    #1;
    checks++;
    if (grant !== 2'b00 || de_req !== 1'b0) begin
      errors++;
      $display("FAIL single_idle grant=%b de_req=%b exp=00/0", grant, de_req);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (grant !== 2'b01 || ack !== 2'b01 || de_addr !== 18'h00100 + AW'(k)) begin
        errors++;
        $display("FAIL single_beat k=%0d grant=%b ack=%b addr=%h", k, grant, ack, de_addr);
      end
      step();
    end
    #1;
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1 || de_req !== 1'b0 || ack !== 2'b00) begin
      errors++;
      $display("FAIL single_drop grant=%b busy=%b de_req=%b ack=%b", grant, busy, de_req, ack);
    end
    step();
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle2 grant=%b busy=%b exp=00/0", grant, busy);
    end
  endtask

  task automatic test_stall();
    de_ack = 0;
    load(0, 1, 18'h2AAAA);
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (de_req !== 1'b1 || de_addr !== 18'h2AAAA || ack !== 2'b00 || grant !== 2'b01) begin
        errors++;
        $display("FAIL stall k=%0d de_req=%b addr=%h ack=%b grant=%b", k, de_req, de_addr, ack, grant);
      end
      step();
    end
    de_ack = 1;
    #1;
    checks++;
    if (ack !== 2'b01) begin
      errors++;
      $display("FAIL stall_release ack=%b exp=01", ack);
    end
    step();
    #1;
    checks++;
    if (ack !== 2'b00 || de_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_single_pulse ack=%b de_req=%b exp=00/0", ack, de_req);
    end
    drain();
  endtask

  task automatic test_no_contender();
    de_ack = 1;
    load(1, 40, 18'h3F000);
    step();
    for (int k = 0; k < 40; k++) begin
      #1;
      checks++;
      if (grant !== 2'b10 || ack !== 2'b10) begin
        errors++;
        $display("FAIL no_contender k=%0d grant=%b ack=%b exp=10", k, grant, ack);
      end
      step();
    end
    drain();
  endtask

  task automatic test_async_reset();
    de_ack = 1;
    load(1, 20, 18'h00500);
    step();
    for (int k = 0; k < 7; k++) step();
    #1;
    checks++;
    if (grant !== 2'b10 || ack !== 2'b10 || de_addr !== 18'h00507) begin
      errors++;
      $display("FAIL areset_pre grant=%b ack=%b addr=%h exp=10/10/00507", grant, ack, de_addr);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({grant, busy, de_req, ack} !== '0) begin
      errors++;
      $display("FAIL areset_drop grant=%b busy=%b de_req=%b ack=%b exp_zero", grant, busy, de_req, ack);
    end
    q0.delete();
    q1.delete();
    rem[0] = 0;
    rem[1] = 0;
    req = '0;
    @(posedge clk);
    #1;
    load(0, 3, 18'h00700);
    load(1, 3, 18'h00800);
    rst = 0;
    step();
    #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL areset_first_grant grant=%b exp=01", grant);
    end
    drain();
  endtask

  initial begin
    rem[0] = 0;
    rem[1] = 0;
    test_reset();
    test_contention();
    test_single();
    test_stall();
    test_no_contender();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
